d_sram_like_bridge: RTL and testbench
=====================================

Name: d_sram_like_bridge

Overview:
- Converts the pipeline's single-cycle data-SRAM port (mem stage: enable, byte-select, address, write data) into a split-transaction sram-like bus (req / addr_ok / data_ok).
- Raises a data stall to the hazard unit until the access completes, and holds the load result stable until the whole pipeline advances.
- Sits directly downstream of the mem stage and upstream of the AXI/cache interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (SEL_W = DATA_W/8)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
data_sram_en  in  1  mem-stage access request (load or store)
data_sram_wen  in  SEL_W  byte write enables; 0 = load
data_sram_size  in  2  access size: 0 byte, 1 half, 2 word
data_sram_addr  in  ADDR_W  byte address
data_sram_wdata  in  DATA_W  lane-aligned store data
data_sram_rdata  out  DATA_W  load data returned to the mem stage
flush_i  in  1  exception flush of the mem-stage instruction
longest_stall  in  1  OR of all pipeline stalls, including d_stall
d_stall  out  1  stall request to the hazard unit
data_req  out  1  bus request
data_wr  out  1  1 = write
data_size  out  2  bus size
data_addr  out  ADDR_W  bus address
data_wdata  out  DATA_W  bus write data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  write done / read data valid
data_rdata  in  DATA_W  bus read data

Behaviour:
- FSM states: IDLE, ADDR, DATA, DONE. Reset puts the FSM in IDLE. data_req, d_stall and data_sram_rdata reset to 0.
- IDLE:
  - If data_sram_en & ~flush_i, go to ADDR. d_stall is asserted combinationally in this same cycle.
  - If flush_i is high, do not issue.
- ADDR:
  - data_req=1.
  - data_wr = |data_sram_wen.
  - data_size, data_addr and data_wdata are driven from registers captured on IDLE exit, so they stay stable while the pipeline is stalled.
  - On data_addr_ok, go to DATA and drop data_req the next cycle.
  - req is never withdrawn before addr_ok, even if flush_i rises.
- DATA:
  - On data_data_ok, register data_rdata into the rdata buffer and go to DONE.
  - A data_ok in the same cycle as addr_ok is not legal on this bus.
- DONE:
  - d_stall=0. data_sram_rdata = buffered value.
  - When ~longest_stall, go to IDLE; the pipeline advances on that edge.
  - While longest_stall stays high (another stall source), remain in DONE. Never re-issue the same access.
- d_stall = data_sram_en & ~flush_i & (state != DONE). Minimum load/store latency is 3 cycles (IDLE→ADDR→DATA→DONE), with 1-cycle addr_ok and data_ok.
- Flush:
  - flush_i while in ADDR or DATA lets the transaction finish, then the FSM goes to IDLE without entering DONE.
  - d_stall stays low from the flush cycle onward.
  - The rdata buffer is not updated.
- Stores: data_sram_rdata is unchanged.
- Bus address is data_sram_addr unmodified. Size and byte lanes are already resolved upstream.
- Synchronous rst in any state returns to IDLE. The interconnect is reset by the same rst, so no orphan response arrives.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, ADDR=2'd1, DATA=2'd2, DONE=2'd3.
  - Size constants SZ_BYTE/SZ_HALF/SZ_WORD.
- Sub-module: the same FSM is reused for the instruction side as i_sram_like_bridge. Extract the core as sram_like_fsm, parameterised with a write-path enable.

Test Plan:
- Word load, addr 0x1000, addr_ok and data_ok each 1 cycle, rdata 0xDEADBEEF:
  - data_req high for 1 cycle with data_wr=0, size=2.
  - d_stall high for exactly 3 cycles.
  - data_sram_rdata=0xDEADBEEF in DONE.
- Byte store, wen=4'b0100, wdata 0x00AB0000, addr_ok delayed 4 cycles:
  - data_req held 5 cycles.
  - addr, wdata, size=0, wr=1 stable throughout.
- Load completes while longest_stall is held 3 more cycles by another source:
  - FSM stays in DONE, rdata stable, no second data_req.
  - Returns to IDLE on the first cycle longest_stall=0.
- flush_i asserted in DATA:
  - data_ok is consumed, rdata buffer unchanged, d_stall=0 from the flush cycle.
  - Next state is IDLE.
- flush_i together with data_sram_en in IDLE: no data_req, d_stall=0.
- rst pulsed in ADDR: next cycle data_req=0, d_stall=0, state IDLE.

Source files
------------

// File: rtl/d_sram_like_bridge_pkg.sv
// Shared definitions for the sram-like bridges: FSM state encoding and bus size codes.
package d_sram_like_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } bridgeStateT;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/d_sram_like_bridge_fsm.sv
// Split-transaction core shared by the data and instruction bridges; WRITE_EN=0
// strips the store path so the instruction side only ever issues reads.
module sram_like_fsm
    import d_sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter bit WRITE_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_W/8-1:0]   wen,
    input  logic [1:0]            size,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  flush,
    input  logic                  longestStall,
    output logic [DATA_W-1:0]     rdata,
    output logic                  stall,
    output logic                  busReq,
    output logic                  busWr,
    output logic [1:0]            busSize,
    output logic [ADDR_W-1:0]     busAddr,
    output logic [DATA_W-1:0]     busWdata,
    input  logic                  busAddrOk,
    input  logic                  busDataOk,
    input  logic [DATA_W-1:0]     busRdata
);

    bridgeStateT          state_r;
    logic                 req_r;
    logic                 wr_r;
    logic [1:0]           size_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [DATA_W-1:0]    wdata_r;
    logic [DATA_W-1:0]    rdata_r;
    logic                 flushed_r;

    // Stall must rise in the same cycle the access is presented, so it cannot be registered.
    assign stall    = en & ~flush & (state_r != DONE);
    assign busReq   = req_r;
    assign busWr    = wr_r;
    assign busSize  = size_r;
    assign busAddr  = addr_r;
    assign busWdata = wdata_r;
    assign rdata    = rdata_r;

    // Transaction sequencer: capture request on IDLE exit, hold it until the bus accepts,
    // then wait for the response and park in DONE until the pipeline moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            req_r     <= 1'b0;
            wr_r      <= 1'b0;
            size_r    <= 2'd0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            rdata_r   <= {DATA_W{1'b0}};
            flushed_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    flushed_r <= 1'b0;
                    if (en && !flush) begin
                        state_r <= ADDR;
                        req_r   <= 1'b1;
                        wr_r    <= WRITE_EN ? (|wen) : 1'b0;
                        size_r  <= size;
                        addr_r  <= addr;
                        wdata_r <= WRITE_EN ? wdata : {DATA_W{1'b0}};
                    end
                end
                ADDR: begin
                    // A flushed request still completes on the bus; only its result is dropped.
                    if (flush) begin
                        flushed_r <= 1'b1;
                    end
                    if (busAddrOk) begin
                        state_r <= DATA;
                        req_r   <= 1'b0;
                    end
                end
                DATA: begin
                    if (busDataOk) begin
                        if (flushed_r || flush) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= DONE;
                            if (!wr_r) begin
                                rdata_r <= busRdata;
                            end
                        end
                    end else if (flush) begin
                        flushed_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (!longestStall) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/d_sram_like_bridge.sv
// Data-side bridge: mem-stage single-cycle SRAM port to sram-like split-transaction bus.
module d_sram_like_bridge
    import d_sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_sram_en,
    input  logic [DATA_W/8-1:0]   data_sram_wen,
    input  logic [1:0]            data_sram_size,
    input  logic [ADDR_W-1:0]     data_sram_addr,
    input  logic [DATA_W-1:0]     data_sram_wdata,
    output logic [DATA_W-1:0]     data_sram_rdata,
    input  logic                  flush_i,
    input  logic                  longest_stall,
    output logic                  d_stall,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_W-1:0]     data_addr,
    output logic [DATA_W-1:0]     data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_W-1:0]     data_rdata
);

    sram_like_fsm #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WRITE_EN (1'b1)
    ) uFsm (
        .clk          (clk),
        .rst          (rst),
        .en           (data_sram_en),
        .wen          (data_sram_wen),
        .size         (data_sram_size),
        .addr         (data_sram_addr),
        .wdata        (data_sram_wdata),
        .flush        (flush_i),
        .longestStall (longest_stall),
        .rdata        (data_sram_rdata),
        .stall        (d_stall),
        .busReq       (data_req),
        .busWr        (data_wr),
        .busSize      (data_size),
        .busAddr      (data_addr),
        .busWdata     (data_wdata),
        .busAddrOk    (data_addr_ok),
        .busDataOk    (data_data_ok),
        .busRdata     (data_rdata)
    );

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Scoreboard bench for d_sram_like_bridge with a programmable-latency bus responder.
module tb_d_sram_like_bridge;
    import d_sram_like_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'd0;
    logic [1:0]  data_sram_size = 2'd0;
    logic [31:0] data_sram_addr = 32'd0;
    logic [31:0] data_sram_wdata = 32'd0;
    logic [31:0] data_sram_rdata;
    logic        flush_i = 1'b0;
    logic        longest_stall = 1'b0;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;

    d_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
        .flush_i(flush_i), .longest_stall(longest_stall), .d_stall(d_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    logic [1:0] st;
    assign st = dut.uFsm.state_r;

    int totalCnt = 0;
    int badCnt = 0;

    // bus responder settings and model state
    int          addrDelay = 0;
    int          reqCnt = 0;
    logic [31:0] rdVal = 32'd0;
    logic        pend = 1'b0;

    // expected bus-side request fields and monitor tallies
    logic [31:0] expAddr = 32'd0;
    logic [31:0] expWdata = 32'd0;
    logic [1:0]  expSize = 2'd0;
    logic        expWr = 1'b0;
    int reqTotal = 0, stallTotal = 0, doneTotal = 0, stabErr = 0, doneReqErr = 0;
    int reqMark = 0, stallMark = 0, doneMark = 0;

    logic [31:0] expQ[$];
    logic [31:0] bufModel = 32'd0;
    logic [31:0] expRd;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responder: addr_ok after addrDelay cycles of req, data_ok the cycle after acceptance.
    always @(negedge clk) begin
        if (data_req) begin
            data_addr_ok = (reqCnt >= addrDelay);
            reqCnt = reqCnt + 1;
        end else begin
            data_addr_ok = 1'b0;
            reqCnt = 0;
        end
        data_data_ok = pend;
        data_rdata = pend ? rdVal : 32'hFFFF_FFFF;
    end

    always @(posedge clk) begin
        if (rst) pend <= 1'b0;
        else     pend <= data_req && data_addr_ok;
    end

    // Monitor: request-field stability while req is up, cycle tallies, no issue from DONE.
    always @(negedge clk) begin
        if (data_req) begin
            reqTotal = reqTotal + 1;
            if (data_addr !== expAddr || data_wdata !== expWdata ||
                data_size !== expSize || data_wr !== expWr)
                stabErr = stabErr + 1;
        end
        if (d_stall) stallTotal = stallTotal + 1;
        if (st == DONE) begin
            doneTotal = doneTotal + 1;
            if (data_req) doneReqErr = doneReqErr + 1;
        end
    end

    task automatic startAcc(input logic [3:0] wen, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int dly);
        expAddr = a; expWdata = wd; expSize = sz; expWr = |wen;
        rdVal = rd; addrDelay = dly;
        reqMark = reqTotal; stallMark = stallTotal; doneMark = doneTotal;
        data_sram_wen = wen; data_sram_size = sz; data_sram_addr = a;
        data_sram_wdata = wd; data_sram_en = 1'b1;
    endtask

    task automatic pushExp(input bit isLoad, input logic [31:0] rd);
        if (isLoad) bufModel = rd;
        expQ.push_back(bufModel);
    endtask

    task automatic waitDone(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!d_stall) begin ok = 1'b1; break; end
        end
        checkEq({tag, "_doneTimeout"}, {31'd0, ok}, 32'd1);
        if (expQ.size() > 0) expRd = expQ.pop_front();
        else expRd = 32'hXXXX_XXXX;
        checkEq({tag, "_state"}, {30'd0, st}, {30'd0, DONE});
        checkEq({tag, "_rdata"}, data_sram_rdata, expRd);
    endtask

    task automatic leaveDone(input string tag, input int expReq, input int expStall);
        tick();
        data_sram_en = 1'b0;
        checkEq({tag, "_idle"}, {30'd0, st}, {30'd0, IDLE});
        checkEq({tag, "_reqCycles"}, reqTotal - reqMark, expReq);
        checkEq({tag, "_stallCycles"}, stallTotal - stallMark, expStall);
    endtask

    initial begin
        tick(); tick();
        checkEq("rst_req", {31'd0, data_req}, 32'd0);
        checkEq("rst_stall", {31'd0, d_stall}, 32'd0);
        checkEq("rst_rdata", data_sram_rdata, 32'd0);
        checkEq("rst_state", {30'd0, st}, {30'd0, IDLE});
        rst = 1'b0;
        tick();

        // word load, single-cycle handshakes
        startAcc(4'b0000, SZ_WORD, 32'h0000_1000, 32'h1111_2222, 32'hDEAD_BEEF, 0);
        pushExp(1'b1, 32'hDEAD_BEEF);
        #1 checkEq("wl_stallSameCycle", {31'd0, d_stall}, 32'd1);
        waitDone("wl");
        leaveDone("wl", 1, 3);

        // byte store with addr_ok held off 4 cycles
        startAcc(4'b0100, SZ_BYTE, 32'h0000_2002, 32'h00AB_0000, 32'h7777_7777, 4);
        pushExp(1'b0, 32'd0);
        waitDone("bs");
        leaveDone("bs", 5, 7);

        // halfword load, addr_ok after 1 cycle
        startAcc(4'b0000, SZ_HALF, 32'h0000_3006, 32'h0, 32'h0000_CAFE, 1);
        pushExp(1'b1, 32'h0000_CAFE);
        waitDone("hl");
        leaveDone("hl", 2, 4);

        // load finishing while another stall source holds the pipeline
        startAcc(4'b0000, SZ_WORD, 32'h0000_4000, 32'h0, 32'h0BAD_F00D, 0);
        pushExp(1'b1, 32'h0BAD_F00D);
        waitDone("ls");
        longest_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkEq("ls_holdDone", {30'd0, st}, {30'd0, DONE});
            checkEq("ls_holdRdata", data_sram_rdata, 32'h0BAD_F00D);
        end
        longest_stall = 1'b0;
        leaveDone("ls", 1, 3);
        checkEq("ls_doneCycles", doneTotal - doneMark, 32'd4);

        // flush in DATA coincident with data_ok
        startAcc(4'b0000, SZ_WORD, 32'h0000_5000, 32'h0, 32'h1234_5678, 0);
        tick(); tick();
        checkEq("fd_inData", {30'd0, st}, {30'd0, DATA});
        flush_i = 1'b1;
        #1 checkEq("fd_stallLow", {31'd0, d_stall}, 32'd0);
        tick();
        checkEq("fd_stallLow2", {31'd0, d_stall}, 32'd0);
        flush_i = 1'b0; data_sram_en = 1'b0;
        checkEq("fd_idle", {30'd0, st}, {30'd0, IDLE});
        checkEq("fd_rdataKept", data_sram_rdata, bufModel);
        tick();
        checkEq("fd_noReissue", {31'd0, data_req}, 32'd0);

        // flush during ADDR: request still held until accepted, result dropped
        startAcc(4'b0000, SZ_WORD, 32'h0000_6000, 32'h0, 32'h55AA_55AA, 2);
        tick();
        flush_i = 1'b1;
        #1 checkEq("fa_stallLow", {31'd0, d_stall}, 32'd0);
        tick();
        checkEq("fa_reqHeld", {31'd0, data_req}, 32'd1);
        flush_i = 1'b0; data_sram_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (st == IDLE) break;
            tick();
        end
        checkEq("fa_idle", {30'd0, st}, {30'd0, IDLE});
        checkEq("fa_reqCycles", reqTotal - reqMark, 32'd3);
        checkEq("fa_noDone", doneTotal - doneMark, 32'd0);
        checkEq("fa_rdataKept", data_sram_rdata, bufModel);

        // flush together with en in IDLE
        startAcc(4'b0000, SZ_WORD, 32'h0000_7000, 32'h0, 32'h0, 0);
        flush_i = 1'b1;
        #1 checkEq("fi_stallLow", {31'd0, d_stall}, 32'd0);
        tick();
        checkEq("fi_noReq", {31'd0, data_req}, 32'd0);
        checkEq("fi_idle", {30'd0, st}, {30'd0, IDLE});
        flush_i = 1'b0; data_sram_en = 1'b0;

        // reset while waiting for addr_ok
        startAcc(4'b0000, SZ_WORD, 32'h0000_8000, 32'h0, 32'h0, 10);
        tick();
        checkEq("ra_reqUp", {31'd0, data_req}, 32'd1);
        rst = 1'b1; data_sram_en = 1'b0;
        tick();
        checkEq("ra_req", {31'd0, data_req}, 32'd0);
        checkEq("ra_stall", {31'd0, d_stall}, 32'd0);
        checkEq("ra_state", {30'd0, st}, {30'd0, IDLE});
        checkEq("ra_rdata", data_sram_rdata, 32'd0);
        rst = 1'b0;
        tick();

        checkEq("busStable", stabErr, 32'd0);
        checkEq("noIssueInDone", doneReqErr, 32'd0);
        checkEq("sbDrained", expQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
